// File: rtl/priority_encoder.sv
// Priority encoder: reports the highest-priority set bit of a request vector.
// Latency: combinational, no registers.
// Backpressure: none; the result follows the input every cycle.
//
// Ports:
//   request  in  WIDTH          request vector
//   valid    out 1              request has at least one bit set
//   index    out $clog2(WIDTH)  binary index of the winning bit (0 when idle)
//   one_hot  out WIDTH          winning bit as a one-hot vector (0 when idle)
module priority_encoder #(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 1
) (
  input  logic [WIDTH-1:0]         request,
  output logic                     valid,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic [WIDTH-1:0]         one_hot
);

  localparam int IDX_W = $clog2(WIDTH);

  always_comb begin
    valid   = |request;
    index   = '0;
    one_hot = '0;
    // The scan runs towards the highest-priority end so the last hit wins.
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (request[i]) index = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (request[i]) index = IDX_W'(i);
      end
    end
    if (valid) one_hot[index] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Registered request arbiter: fixed priority or round-robin, optional grant blocking.
// Latency: 1 cycle from request to grant; every output is a register.
// Backpressure: with blocking, the grant holds until request drop or acknowledge.
//
// Ports:
//   clk            in  1              rising-edge clock
//   rst_n          in  1              asynchronous active-low reset
//   request        in  PORTS          per-port request level
//   acknowledge    in  PORTS          per-port release pulse (block-on-ack mode only)
//   grant          out PORTS          one-hot grant
//   grant_valid    out 1              grant is nonzero
//   grant_encoded  out $clog2(PORTS)  binary index of the granted port
module rr_arbiter #(
  parameter int PORTS                = 4,
  parameter int ARB_TYPE_ROUND_ROBIN = 1,
  parameter int ARB_BLOCK            = 0,
  parameter int ARB_BLOCK_ACK        = 0,
  parameter int LSB_HIGH_PRIORITY    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded
);

  localparam int IDX_W = $clog2(PORTS);

  logic [PORTS-1:0] mask;
  logic [PORTS-1:0] masked_request;

  logic             req_vld;
  logic [IDX_W-1:0] req_idx;
  logic [PORTS-1:0] req_oh;
  logic             msk_vld;
  logic [IDX_W-1:0] msk_idx;
  logic [PORTS-1:0] msk_oh;

  logic [PORTS-1:0] grant_next;
  logic             grant_valid_next;
  logic [IDX_W-1:0] grant_encoded_next;
  logic [PORTS-1:0] mask_next;
  logic             hold;

  assign masked_request = request & mask;

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
  ) u_enc_req (
    .request (request),
    .valid   (req_vld),
    .index   (req_idx),
    .one_hot (req_oh)
  );

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
  ) u_enc_msk (
    .request (masked_request),
    .valid   (msk_vld),
    .index   (msk_idx),
    .one_hot (msk_oh)
  );

  always_comb begin
    grant_next         = grant;
    grant_valid_next   = grant_valid;
    grant_encoded_next = grant_encoded;
    mask_next          = mask;

    hold = 1'b0;
    if (ARB_BLOCK != 0) begin
      if (ARB_BLOCK_ACK != 0) begin
        // Ack mode keeps the grant even after its request drops.
        hold = grant_valid && ((grant & acknowledge) == '0);
      end else begin
        hold = grant_valid && ((grant & request) != '0);
      end
    end

    if (!hold) begin
      if (req_vld) begin
        // Masked winner takes precedence; an empty mask wraps to the base winner.
        if ((ARB_TYPE_ROUND_ROBIN != 0) && msk_vld) begin
          grant_next         = msk_oh;
          grant_encoded_next = msk_idx;
        end else begin
          grant_next         = req_oh;
          grant_encoded_next = req_idx;
        end
        grant_valid_next = 1'b1;
        // Mask keeps only ports of lower priority than the new winner.
        for (int i = 0; i < PORTS; i++) begin
          if (LSB_HIGH_PRIORITY != 0) begin
            mask_next[i] = (i > int'(grant_encoded_next));
          end else begin
            mask_next[i] = (i < int'(grant_encoded_next));
          end
        end
      end else begin
        // Idle: outputs clear, mask retained so rotation resumes where it left off.
        grant_next         = '0;
        grant_valid_next   = 1'b0;
        grant_encoded_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask          <= '0;
    end else begin
      grant         <= grant_next;
      grant_valid   <= grant_valid_next;
      grant_encoded <= grant_encoded_next;
      mask          <= mask_next;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: several parameter sets, hand-computed expectations.
module tb_rr_arbiter;

  logic clk;
  logic rst_n;
  logic [3:0] ack_zero;

  logic [3:0] req_rr, req_fp, req_blk, req_ack, ack_ack;
  logic [3:0] g_rr, g_fp, g_fpm, g_blk, g_ack;
  logic       v_rr, v_fp, v_fpm, v_blk, v_ack;
  logic [1:0] e_rr, e_fp, e_fpm, e_blk, e_ack;

  int tests_run;
  int tests_failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
               .LSB_HIGH_PRIORITY(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .request(req_rr), .acknowledge(ack_zero),
    .grant(g_rr), .grant_valid(v_rr), .grant_encoded(e_rr));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
               .LSB_HIGH_PRIORITY(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .request(req_fp), .acknowledge(ack_zero),
    .grant(g_fp), .grant_valid(v_fp), .grant_encoded(e_fp));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(0),
               .LSB_HIGH_PRIORITY(0)) u_fpm (
    .clk(clk), .rst_n(rst_n), .request(req_fp), .acknowledge(ack_zero),
    .grant(g_fpm), .grant_valid(v_fpm), .grant_encoded(e_fpm));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(0),
               .LSB_HIGH_PRIORITY(1)) u_blk (
    .clk(clk), .rst_n(rst_n), .request(req_blk), .acknowledge(ack_zero),
    .grant(g_blk), .grant_valid(v_blk), .grant_encoded(e_blk));

  rr_arbiter #(.PORTS(4), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1),
               .LSB_HIGH_PRIORITY(1)) u_ack (
    .clk(clk), .rst_n(rst_n), .request(req_ack), .acknowledge(ack_ack),
    .grant(g_ack), .grant_valid(v_ack), .grant_encoded(e_ack));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rr(input string tag, input logic [3:0] g, input logic [1:0] e);
    check({tag, ".grant"}, 32'(g_rr), 32'(g));
    check({tag, ".enc"},   32'(e_rr), 32'(e));
    check({tag, ".vld"},   32'(v_rr), 32'(g != 4'b0000));
  endtask

  logic [3:0] rr_seq [5];
  logic [1:0] rr_enc [5];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ack_zero = 4'b0000;
    req_rr   = 4'b0000;
    req_fp   = 4'b0000;
    req_blk  = 4'b0000;
    req_ack  = 4'b0000;
    ack_ack  = 4'b0000;
    rst_n    = 1'b0;
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_enc = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // 1. Reset: get a live grant, then assert rst_n between edges.
    step();
    rst_n = 1'b1;
    req_rr = 4'b1111;
    step();
    check_rr("pre_reset", 4'b0001, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_rr("async_reset", 4'b0000, 2'd0);
    req_rr = 4'b0000;
    step();
    #3;
    rst_n = 1'b1;
    step();
    check_rr("reset_release_idle", 4'b0000, 2'd0);
    step();
    check_rr("reset_release_idle2", 4'b0000, 2'd0);

    // 2. Round-robin rotation under full request.
    req_rr = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check_rr($sformatf("rr_rot%0d", i), rr_seq[i], rr_enc[i]);
    end
    step(); step(); step();
    check_rr("rr_at3", 4'b1000, 2'd3);
    req_rr = 4'b1010;
    step();
    check_rr("rr_wrap", 4'b0010, 2'd1);
    step();
    check_rr("rr_masked", 4'b1000, 2'd3);
    req_rr = 4'b0000;
    step();
    check_rr("rr_idle", 4'b0000, 2'd0);
    req_rr = 4'b0110;
    step();
    check_rr("rr_after_idle", 4'b0010, 2'd1);

    // 3. Fixed priority, both priority orders.
    req_fp = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fp_lsb_grant%0d", i), 32'(g_fp),  32'h2);
      check($sformatf("fp_lsb_enc%0d", i),   32'(e_fp),  32'd1);
      check($sformatf("fp_msb_grant%0d", i), 32'(g_fpm), 32'h8);
      check($sformatf("fp_msb_enc%0d", i),   32'(e_fpm), 32'd3);
    end
    check("fp_vld", 32'(v_fp & v_fpm), 32'd1);

    // 4. Block until request drop.
    req_blk = 4'b0011;
    step();
    check("blk_first", 32'(g_blk), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("blk_hold%0d", i), 32'(g_blk), 32'h1);
    end
    req_blk = 4'b0010;
    step();
    check("blk_release_grant", 32'(g_blk), 32'h2);
    check("blk_release_enc",   32'(e_blk), 32'd1);
    check("blk_release_vld",   32'(v_blk), 32'd1);

    // 5. Block until acknowledge.
    req_ack = 4'b0011;
    step();
    check("ack_first", 32'(g_ack), 32'h1);
    req_ack = 4'b0010;
    step();
    check("ack_req_drop_hold", 32'(g_ack), 32'h1);
    check("ack_req_drop_vld",  32'(v_ack), 32'd1);
    ack_ack = 4'b0010;
    step();
    ack_ack = 4'b0000;
    check("ack_wrong_bit_hold", 32'(g_ack), 32'h1);
    step();
    check("ack_idle_hold", 32'(g_ack), 32'h1);
    ack_ack = 4'b0001;
    step();
    ack_ack = 4'b0000;
    check("ack_release_grant", 32'(g_ack), 32'h2);
    check("ack_release_enc",   32'(e_ack), 32'd1);
    step();
    check("ack_new_hold", 32'(g_ack), 32'h2);

    // 6. Reset mid-sequence clears the rotation mask.
    req_rr = 4'b1111;
    step();
    check_rr("mid_pre", 4'b0100, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_rr("mid_reset", 4'b0000, 2'd0);
    #3;
    rst_n = 1'b1;
    step();
    check_rr("mid_first_after", 4'b0001, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Registered, parametrised request arbiter for N requesters.
- Selects one requester per decision and presents the winner as a one-hot grant plus a binary index.
- Modes: fixed priority or round-robin (rotating mask); optional grant blocking, released either by request drop or by an explicit acknowledge.
- Sits in front of shared resources (muxes, shared buses, switch outputs); generalises the existing combinational priority encoder into a stateful arbiter.

Parameters:
- PORTS, 4: number of requesters; legal range 2 to 256.
- ARB_TYPE_ROUND_ROBIN, 1: 1 = round-robin, 0 = fixed priority.
- ARB_BLOCK, 0: 1 = hold the current grant until release.
- ARB_BLOCK_ACK, 0: release condition when ARB_BLOCK=1. 1 = release on acknowledge; 0 = release on request drop.
- LSB_HIGH_PRIORITY, 1: 1 = index 0 has highest base priority; 0 = index PORTS-1 has highest base priority.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- request  in  PORTS  per-port request level.
- acknowledge  in  PORTS  per-port grant release pulse; used only when ARB_BLOCK=1 and ARB_BLOCK_ACK=1.
- grant  out  PORTS  one-hot registered grant.
- grant_valid  out  1  grant is nonzero.
- grant_encoded  out  $clog2(PORTS)  binary index of the granted port.

Behaviour:
- Reset: asserting rst_n low immediately clears grant, grant_valid, grant_encoded and the internal mask to 0, independent of clk.
- Registers: every output is a register. Latency is 1 cycle from request to grant.
- Hold rule: the next state equals the current state when either condition holds:
  - ARB_BLOCK=1, ARB_BLOCK_ACK=0, grant_valid=1 and (grant & request) != 0.
  - ARB_BLOCK=1, ARB_BLOCK_ACK=1, grant_valid=1 and (grant & acknowledge) == 0.
  - In ack mode the grant holds even if its request drops.
- Arbitration, when not holding and request != 0:
  - Fixed priority: grant the highest-priority set bit of request.
  - Round-robin, masked request (request & mask) != 0: grant the highest-priority bit of the masked request.
  - Round-robin, masked request == 0: grant the highest-priority bit of the unmasked request. This is the wrap-around case.
  - Set grant_encoded to the winner index and grant_valid to 1.
- Mask update, on every new grant at index k:
  - LSB_HIGH_PRIORITY=1: mask = all-ones << (k+1), i.e. bits above k.
  - LSB_HIGH_PRIORITY=0: mask = all-ones >> (PORTS-k), i.e. bits below k.
  - For k = PORTS-1 (LSB high) or k = 0 (MSB high) the mask becomes 0.
- Idle, when not holding and request == 0: grant, grant_valid and grant_encoded go to 0; the mask is retained.
- Acknowledge outside the hold condition: ignored.
- Acknowledge on a non-granted bit: ignored.
- Simultaneous release and new request: the release and a new arbitration happen in the same cycle. The next grant is visible the following cycle, with no idle bubble.
- Reset mid-operation: after rst_n rises the mask is 0, so the first grant is the base-priority winner.
- Invariant: grant always has at most one bit set.

Decomposition:
- No shared package needed. Mask shifts are computed locally from the $clog2(PORTS)-sized index.
- Two instances of the existing priority_encoder (WIDTH=PORTS, LSB_HIGH_PRIORITY passed through): one on request, one on request & mask.
- Next-state logic is a single combinational block; the mask and output registers are a single sequential block.

Test Plan (PORTS=4, LSB_HIGH_PRIORITY=1 unless stated):
1. Reset: drive rst_n low asynchronously mid-cycle -> grant=0000, grant_valid=0 and grant_encoded=0 immediately. Release with request=0000 -> outputs stay 0.
2. Round-robin, no block: hold request=1111 -> grants on successive cycles are 0001, 0010, 0100, 1000, 0001 (grant_encoded 0, 1, 2, 3, 0). Then request=1010 after the grant at index 3 -> wraps to 0010.
3. Fixed priority (ARB_TYPE_ROUND_ROBIN=0): request=1010 held -> grant=0010 every cycle. With LSB_HIGH_PRIORITY=0 -> grant=1000.
4. Block on request (ARB_BLOCK=1, ARB_BLOCK_ACK=0): request=0011 -> grant 0001, held for 5 cycles. Drop request[0] -> the cycle after, grant=0010 with no idle cycle.
5. Block on ack (ARB_BLOCK=1, ARB_BLOCK_ACK=1):
   - request=0011 -> grant=0001.
   - Drop request[0] -> grant stays 0001.
   - Pulse acknowledge=0010 -> grant stays 0001.
   - Pulse acknowledge=0001 -> next cycle grant=0010.
6. Reset mid-sequence: after grant reaches 0100 under request=1111, pulse rst_n low -> outputs 0. After release, the first grant is 0001 (mask cleared), not 1000.
